// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU port (C) and
// the debug/program-loader port (D). One access at a time, fixed latency,
// round-robin on contention, every output driven straight from a register.
module mem_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1   // memory read latency, 1..15
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter reload value: ACCESS runs while the counter walks down to 0.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;     // 1 = D owns the current access
    logic          last_q, last_d;       // 1 = D won the previous arbitration
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
    logic          c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic          pick_d;

    // Next-state, arbitration and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default here so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        c_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        pick_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    // On a tie the side that did not win last time goes first.
                    pick_d  = d_req && (!c_req || !last_q);
                    owner_d = pick_d;
                    last_d  = pick_d;
                    we_d    = pick_d ? d_we    : c_we;
                    addr_d  = pick_d ? d_addr  : c_addr;
                    wdata_d = pick_d ? d_wdata : c_wdata;
                    cnt_d   = LAT_M1;
                    c_gnt_d = !pick_d;
                    d_gnt_d = pick_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last ACCESS cycle: memory data is valid now.
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = mem_rdata;
                        else         c_rdata_d = mem_rdata;
                    end
                    c_rvalid_d = !owner_q;
                    d_rvalid_d = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_en_d = (state_d == ACCESS);
        mem_we_d = mem_en_d && we_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c_gnt_q    <= c_gnt_d;
            d_gnt_q    <= d_gnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign c_gnt     = c_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign c_rvalid  = c_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port instruction/data memory between two requesters: the CPU control/datapath (port C) and the debug/program-loader port (port D).
- Serialises accesses, holds the memory interface for a fixed latency and returns read data with a one-cycle valid pulse.
- Round-robin on contention, so neither side starves.
- Sits between the CPU address mux and the memory model.

Parameters:
- AW, 5, address width in bits.
- DW, 8, data width in bits.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_  in  1  synchronous active-low reset.
- c_req  in  1  CPU access request; held until c_gnt.
- c_we  in  1  CPU write enable (1=write, 0=read).
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  one-cycle pulse: CPU request accepted.
- c_rvalid  out  1  one-cycle pulse: CPU access complete.
- c_rdata  out  DW  CPU read data; valid with c_rvalid.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the CPU set, for the debug port.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en first rises.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, including mem_addr, mem_wdata, c_rdata and d_rdata.
  - last_owner is set to D, so the CPU wins the first tie.
  - The latency counter is cleared.
- Reset mid-operation: the next edge forces IDLE. The in-flight access is abandoned, and no gnt or rvalid is issued for it.
- All outputs are registered; there is no combinational path from req to gnt or to mem_*.
- IDLE:
  - At the sampling edge, the winner is chosen as follows:
    - Only c_req high: C wins.
    - Only d_req high: D wins.
    - Both high: the port not equal to last_owner wins.
  - On a win:
    - Latch the winner's we, addr and wdata.
    - Set owner and last_owner to the winner.
    - Load the counter with MEM_LAT-1.
    - Go to ACCESS.
    - Set the winner's gnt high for exactly the first ACCESS cycle.
  - No request: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we, mem_addr and mem_wdata hold the latched values for every ACCESS cycle.
  - The counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register and go to DONE.
  - ACCESS lasts exactly MEM_LAT cycles.
- DONE:
  - mem_en=0 and mem_we=0.
  - The owner's rvalid is high for one cycle. It is also issued for writes, as a completion acknowledgement.
  - On a write, the owner's rdata keeps its previous value.
  - Next state is IDLE unconditionally.
- Timing:
  - Request sampled at edge T → gnt at T+1 → rvalid at T+1+MEM_LAT.
  - The next arbitration is sampled at T+2+MEM_LAT.
  - Peak throughput is one access per MEM_LAT+2 cycles.
- Requester rules:
  - addr, we and wdata must be stable while req is high and gnt has not been seen.
  - The requester may deassert req in the gnt cycle.
  - A req still high in IDLE after DONE is a new request.
- Requests arriving during ACCESS or DONE are not lost. They are arbitrated once IDLE is re-entered, provided req is still held.
- The rdata registers of the non-owning port are never modified.
- busy = (state != IDLE).
- The state encoding uses an enumerated type with states IDLE, ACCESS and DONE. Illegal encodings recover to IDLE with mem_en=0.

Test Plan:
- Reset then single CPU read: MEM_LAT=1, mem holds 0x3C at addr 5. c_req=1, c_we=0, c_addr=5 sampled at edge T → c_gnt=1 at T+1, mem_en=1 with mem_addr=5 at T+1, c_rvalid=1 and c_rdata=0x3C at T+2, busy=0 at T+3.
- Contention round-robin: c_req and d_req held high continuously, MEM_LAT=1 → gnt order is C, D, C, D with no port granted twice in a row; each gnt is 3 cycles after the previous one.
- Debug write then CPU read: d_req=1, d_we=1, d_addr=0x1F, d_wdata=0xA5 → mem_we=1 for exactly MEM_LAT cycles and d_rvalid pulses with d_rdata unchanged. A following CPU read of 0x1F returns c_rdata=0xA5.
- Latency parameter: MEM_LAT=3 CPU read → mem_en high for exactly 3 cycles, c_rvalid 3 cycles after c_gnt, and rdata is captured in the last ACCESS cycle.
- Late request: d_req rises during a CPU ACCESS → no d_gnt until after c_rvalid; d_gnt appears 2 cycles after c_rvalid (DONE→IDLE→ACCESS).
- Reset mid-access: rst_=0 asserted in an ACCESS cycle with MEM_LAT=3 → the next edge gives busy=0, mem_en=0 and no c_rvalid ever. After reset release, a tied request is granted to C.
